regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_reader_if.sv | 10 +
 rtl/regfile_dump_reader.sv | 120 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Byte stream from the dump reader to the UART transmitter.
// A byte moves on a rising edge where tx_valid && tx_ready; while tx_valid is high and tx_ready low the master holds tx_data and tx_valid.
interface regfile_dump_reader_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every architectural register through one read port and streams
// header, register bytes MSB-first and an XOR checksum over a byte handshake.
module regfile_dump_reader #(
  parameter int         WORD            = 32,
  parameter int         REGISTER_NUMBER = 32,
  parameter logic [7:0] HEADER_BYTE     = 8'hA5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic [$clog2(REGISTER_NUMBER)-1:0] read_select,
  input  logic [WORD-1:0]                    read_data,
  regfile_dump_reader_if.master              tx,
  output logic                               busy,
  output logic                               done,
  output logic [2:0]                         fsm_state
);

  localparam int IDX_W = $clog2(REGISTER_NUMBER);
  localparam int BYTES = WORD / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REGISTER_NUMBER - 1);
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_SELECT, S_CAPTURE, S_SEND, S_CHECKSUM, S_DONE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  index;
  logic [BCW-1:0]    byte_cnt;
  logic [7:0]        checksum;
  logic [WORD-1:0]   shift_reg;
  logic [WORD-1:0]   capture_word;
  logic              xfer;

  assign xfer      = tx.tx_valid && tx.tx_ready;
  assign fsm_state = state;
  // x0 is hardwired zero architecturally, so it is reported as zero whatever the port returns.
  assign capture_word = (index == '0) ? '0 : read_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      read_select <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      index       <= '0;
      byte_cnt    <= '0;
      checksum    <= '0;
      shift_reg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            tx.tx_data  <= HEADER_BYTE;
            tx.tx_valid <= 1'b1;
            busy        <= 1'b1;
            checksum    <= '0;
            index       <= '0;
            state       <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (xfer) begin
            read_select <= index;
            tx.tx_valid <= 1'b0;
            state       <= S_SELECT;
          end
        end
        S_SELECT: state <= S_CAPTURE;
        S_CAPTURE: begin
          tx.tx_data  <= capture_word[WORD-1 -: 8];
          shift_reg   <= capture_word << 8;
          tx.tx_valid <= 1'b1;
          byte_cnt    <= '0;
          state       <= S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            checksum <= checksum ^ tx.tx_data;
            if (byte_cnt == LAST_BYTE) begin
              if (index == LAST_IDX) begin
                // Checksum byte must already include the byte leaving now.
                tx.tx_data <= checksum ^ tx.tx_data;
                state      <= S_CHECKSUM;
              end else begin
                index       <= index + 1'b1;
                read_select <= index + 1'b1;
                tx.tx_valid <= 1'b0;
                state       <= S_SELECT;
              end
            end else begin
              tx.tx_data <= shift_reg[WORD-1 -: 8];
              shift_reg  <= shift_reg << 8;
              byte_cnt   <= byte_cnt + 1'b1;
            end
          end
        end
        S_CHECKSUM: begin
          if (xfer) begin
            tx.tx_valid <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          busy        <= 1'b0;
          done        <= 1'b0;
          read_select <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: frame vectors from a table plus hand-written
// restart, start-held and mid-dump reset sequences, checked against a byte queue.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  read_select;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic [2:0]  fsm_state;

  regfile_dump_reader_if bus ();

  regfile_dump_reader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .read_select (read_select),
    .read_data   (read_data),
    .tx          (bus.master),
    .busy        (busy),
    .done        (done),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [32];
  assign read_data = regs[read_select];

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] last_byte = '0;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = '0;
  int         ready_pct = 100;

  typedef struct {
    int         mode;
    int         ready_pct;
    logic [7:0] exp_cks;
    int         restart_at;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Sink side: random ready, changed just after each active edge.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: values at the falling edge are those the next rising edge uses.
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("hold_data", {24'd0, bus.tx_data}, {24'd0, hold_data});
      end
      hold_pending = bus.tx_valid && !bus.tx_ready;
      hold_data    = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        xfer_cnt++;
        last_byte = bus.tx_data;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("stream_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic load_regs(input int mode);
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       regs[i] = 32'h01010101 * 32'(i);
        1:       regs[i] = 32'hDEADBEEF;
        default: regs[i] = (i == 1) ? 32'h000000FF : 32'h0;
      endcase
    end
  endtask

  task automatic push_frame();
    logic [7:0]  cks;
    logic [31:0] w;
    cks = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 32; i++) begin
      w = (i == 0) ? 32'h0 : regs[i];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[8*b +: 8]);
        cks = cks ^ w[8*b +: 8];
      end
    end
    exp_q.push_back(cks);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
  endtask

  task automatic wait_xfers(input int target);
    for (int n = 0; n < 3000 && xfer_cnt < target; n++) cycle();
    check("xfer_reached", {31'd0, xfer_cnt >= target}, 32'd1);
  endtask

  task automatic run_frame(input int restart_at, input logic [7:0] exp_cks);
    int d0, x0;
    bit ok;
    d0 = done_cnt;
    x0 = xfer_cnt;
    push_frame();
    start = 1'b1;
    cycle();
    start = 1'b0;
    if (restart_at >= 0) begin
      wait_xfers(x0 + restart_at);
      start = 1'b1;
      cycle();
      start = 1'b0;
    end
    wait_done(ok);
    check("done_seen", {31'd0, ok}, 32'd1);
    cycle();
    check("busy_after", {31'd0, busy}, 32'd0);
    check("done_width", {31'd0, done}, 32'd0);
    repeat (5) cycle();
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("frame_len", 32'(xfer_cnt - x0), 32'd130);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("checksum_byte", {24'd0, last_byte}, {24'd0, exp_cks});
  endtask

  initial begin
    bit ok;
    int d0;
    vecs[0] = '{0, 100, 8'h00, -1};
    vecs[1] = '{1, 100, 8'h22, -1};
    vecs[2] = '{2,  30, 8'hFF, -1};
    vecs[3] = '{0,  30, 8'h00, -1};
    vecs[4] = '{0, 100, 8'h00, 20};

    reset = 1'b1;
    start = 1'b0;
    load_regs(0);
    repeat (3) cycle();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sel", {27'd0, read_select}, 32'd0);
      check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    end

    for (int v = 0; v < 5; v++) begin
      load_regs(vecs[v].mode);
      ready_pct = vecs[v].ready_pct;
      cycle();
      run_frame(vecs[v].restart_at, vecs[v].exp_cks);
    end

    // start held high: the next header appears two cycles after the done cycle.
    load_regs(0);
    ready_pct = 100;
    cycle();
    d0 = done_cnt;
    push_frame();
    push_frame();
    start = 1'b1;
    wait_done(ok);
    check("held_done1", {31'd0, ok}, 32'd1);
    @(negedge clk);
    check("held_gap_valid", {31'd0, bus.tx_valid}, 32'd0);
    @(negedge clk);
    check("held_restart_valid", {31'd0, bus.tx_valid}, 32'd1);
    check("held_restart_hdr", {24'd0, bus.tx_data}, 32'hA5);
    start = 1'b0;
    wait_done(ok);
    check("held_done2", {31'd0, ok}, 32'd1);
    repeat (4) cycle();
    check("held_done_cnt", 32'(done_cnt - d0), 32'd2);
    check("held_queue", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a dump abandons the frame.
    d0 = done_cnt;
    push_frame();
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_xfers(xfer_cnt + 40);
    reset = 1'b1;
    cycle();
    check("midrst_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_state", {29'd0, fsm_state}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (5) cycle();
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_idle", {31'd0, busy}, 32'd0);
    run_frame(-1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
